// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared constants, state encoding and iteration counts for multdiv_unit
// MULTDIV_RADIX4_EN selects the radix-4 Booth multiply iteration count.
package multdiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic [4:0] MULT = 5'b00110;
  localparam logic [4:0] DIV  = 5'b00111;

  localparam int MULT_ITERS_R2 = WIDTH_DEFAULT;
  localparam int MULT_ITERS_R4 = WIDTH_DEFAULT / 2;
  localparam int DIV_ITERS     = WIDTH_DEFAULT;

  function automatic int mult_iters(input int w);
`ifdef MULTDIV_RADIX4_EN
    return w / 2;
`else
    return w;
`endif
  endfunction

  function automatic int div_iters(input int w);
    return w;
  endfunction

endpackage

// File: rtl/multdiv_datapath.sv
// rtl/multdiv_datapath.sv - magnitude shift-add multiplier and restoring divider datapath
// MULTDIV_RADIX4_EN switches the multiplier to radix-4 Booth recoding.
module multdiv_datapath
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 iterate,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a_mag,
  input  logic [WIDTH-1:0]     b_mag,
  output logic [2*WIDTH-1:0]   prod_nxt,
  output logic [WIDTH-1:0]     quo_nxt
);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] dsor_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;

`ifdef MULTDIV_RADIX4_EN
  // {hi(W+2, signed), lo(W), booth_prev}
  logic [2*WIDTH+2:0] acc_q;
  logic [2*WIDTH+2:0] acc_d;
  logic [WIDTH+1:0]   mc_ext;
  logic [WIDTH+1:0]   pp;
  logic [WIDTH+1:0]   hi_sum;
  logic               b_msb_q;

  always_comb begin
    mc_ext = {2'b00, mcand_q};
    pp     = '0;
    case (acc_q[2:0])
      3'b001, 3'b010: pp = mc_ext;
      3'b011:         pp = mc_ext << 1;
      3'b100:         pp = -(mc_ext << 1);
      3'b101, 3'b110: pp = -mc_ext;
      default:        pp = '0;
    endcase
    hi_sum = acc_q[2*WIDTH+2:WIDTH+1] + pp;
    acc_d  = {{2{hi_sum[WIDTH+1]}}, hi_sum, acc_q[WIDTH:2]};
    // Booth reads a set magnitude MSB as -2^W; add that weight back.
    prod_nxt = acc_d[2*WIDTH:1] + (b_msb_q ? {mcand_q, {WIDTH{1'b0}}} : {2*WIDTH{1'b0}});
  end
`else
  // {hi(W+1), multiplier(W)}; multiplier bits retire from the bottom
  logic [2*WIDTH:0] acc_q;
  logic [2*WIDTH:0] acc_d;
  logic [WIDTH:0]   hi_sum;

  always_comb begin
    hi_sum   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    acc_d    = {1'b0, hi_sum, acc_q[WIDTH-1:1]};
    prod_nxt = acc_d[2*WIDTH-1:0];
  end
`endif

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dsor_q};
    ge      = ~diff[WIDTH];
    rem_d   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand_q <= '0;
      dsor_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      acc_q   <= '0;
`ifdef MULTDIV_RADIX4_EN
      b_msb_q <= 1'b0;
`endif
    end else if (load) begin
      mcand_q <= a_mag;
      dsor_q  <= b_mag;
      rem_q   <= '0;
      quo_q   <= a_mag;
`ifdef MULTDIV_RADIX4_EN
      acc_q   <= {{(WIDTH+2){1'b0}}, b_mag, 1'b0};
      b_msb_q <= b_mag[WIDTH-1];
`else
      acc_q   <= {{(WIDTH+1){1'b0}}, b_mag};
`endif
    end else if (iterate) begin
      if (is_div) begin
        rem_q <= rem_d;
        quo_q <= quo_nxt;
      end else begin
        acc_q <= acc_d;
      end
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed multiply/divide unit with pipeline stall for the EX stage
// MULTDIV_RADIX4_EN halves multiply latency via radix-4 Booth; results are unchanged.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_rdy,
  output logic             stall
);

  localparam int CW        = $clog2(WIDTH);
  localparam int MULT_LAST = mult_iters(WIDTH) - 1;
  localparam int DIV_LAST  = div_iters(WIDTH) - 1;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             sign_q;
  logic             start;
  logic             start_div;
  logic             div_zero;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_signed;
  logic [WIDTH-1:0]   fix_result;
  logic               fix_exc;

  assign start     = ctrl_mult | ctrl_div;
  assign start_div = ctrl_div & ~ctrl_mult;
  assign div_zero  = start_div && (operand_b == '0);
  assign a_mag     = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign b_mag     = operand_b[WIDTH-1] ? -operand_b : operand_b;
  assign last_iter = cnt_q == (is_div_q ? CW'(DIV_LAST) : CW'(MULT_LAST));

  assign stall      = ((state_q == IDLE) && start) || (state_q == RUN);
  assign result_rdy = state_q == DONE;

  multdiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock    (clock),
    .reset    (reset),
    .load     ((state_q == IDLE) && start && !div_zero),
    .iterate  (state_q == RUN),
    .is_div   (is_div_q),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .prod_nxt (prod_nxt),
    .quo_nxt  (quo_nxt)
  );

  // Only a positive 2^(W-1) quotient overflows, i.e. MIN / -1.
  always_comb begin
    prod_signed = sign_q ? -prod_nxt : prod_nxt;
    quo_signed  = sign_q ? -quo_nxt : quo_nxt;
    fix_result  = prod_signed[WIDTH-1:0];
    fix_exc     = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));
    if (is_div_q) begin
      fix_result = quo_signed;
      fix_exc    = !sign_q && quo_nxt[WIDTH-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      sign_q    <= 1'b0;
      result    <= '0;
      exception <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_zero) begin
            state_q   <= DONE;
            result    <= '0;
            exception <= 1'b1;
          end else if (start) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            is_div_q <= start_div;
            sign_q   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            state_q   <= DONE;
            result    <= fix_result;
            exception <= fix_exc;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - directed self-checking bench for multdiv_unit against an arithmetic model
module tb_multdiv_unit;

`ifdef MULTDIV_RADIX4_EN
  localparam int MLAT = 17;
`else
  localparam int MLAT = 33;
`endif
  localparam int DLAT = 33;

  logic        clk;
  logic        rst_n;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result;
  logic        exception;
  logic        result_rdy;
  logic        stall;

  int total = 0;
  int bad   = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock      (clk),
    .reset      (rst_n),
    .ctrl_mult  (ctrl_mult),
    .ctrl_div   (ctrl_div),
    .operand_a  (op_a),
    .operand_b  (op_b),
    .result     (result),
    .exception  (exception),
    .result_rdy (result_rdy),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model_mult(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[31:0]};
  endfunction

  function automatic logic [32:0] model_div(input logic [31:0] a, input logic [31:0] b);
    longint q;
    if (b == 32'd0) return {1'b1, 32'd0};
    q = longint'($signed(a)) / longint'($signed(b));
    return {(q > 64'sd2147483647), q[31:0]};
  endfunction

  // Cycle-level expectation: cycles left before the ready cycle, and what it delivers
  int          m_left;
  logic        m_done;
  logic [31:0] m_res;
  logic        m_exc;
  logic [31:0] p_res;
  logic        p_exc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_exc  <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_res  <= p_res;
        m_exc  <= p_exc;
      end
    end else if (ctrl_mult || ctrl_div) begin
      if (ctrl_mult) begin
        {p_exc, p_res} <= model_mult(op_a, op_b);
        m_left <= MLAT - 1;
      end else if (op_b == 32'd0) begin
        {m_exc, m_res} <= model_div(op_a, op_b);
        m_done <= 1'b1;
      end else begin
        {p_exc, p_res} <= model_div(op_a, op_b);
        m_left <= DLAT - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_stall", stall, (m_left > 0) || (m_left == 0 && !m_done && (ctrl_mult || ctrl_div)));
    chk("cyc_rdy", result_rdy, m_done);
    chk("cyc_result", result, m_res);
    chk("cyc_exception", exception, m_exc);
  end

  task automatic run_op(input string nm, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee, input int lat, input bit poke);
    int n;
    n = 0;
    @(posedge clk); #2;
    ctrl_mult = m; ctrl_div = d; op_a = a; op_b = b;
    @(posedge clk); #2;
    ctrl_mult = 1'b0; ctrl_div = 1'b0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (result_rdy) break;
      if (n == 2) begin
        #1 op_a = $urandom; op_b = $urandom;
      end
      if (poke && n == 5) begin
        #1 ctrl_div = 1'b1;
      end else if (poke && n == 6) begin
        #1 ctrl_div = 1'b0;
      end
    end
    chk({nm, "_latency"}, n, lat);
    chk({nm, "_result"}, result, er);
    chk({nm, "_exception"}, exception, ee);
    @(negedge clk);
    chk({nm, "_rdy_single"}, result_rdy, 1'b0);
  endtask

  initial begin
    int rdy_cnt;
    rst_n = 1'b0; ctrl_mult = 1'b1; ctrl_div = 1'b0; op_a = 32'd5; op_b = 32'd3;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1; ctrl_mult = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_result", result, 0);
      chk("reset_rdy", result_rdy, 0);
      chk("reset_stall", stall, 0);
    end

    chk("model_mult_7x-3", model_mult(32'd7, 32'hFFFFFFFD), 33'h0_FFFFFFEB);
    chk("model_div_-100/7", model_div(32'hFFFFFF9C, 32'd7), 33'h0_FFFFFFF2);
    chk("model_div_min/-1", model_div(32'h80000000, 32'hFFFFFFFF), 33'h1_80000000);

    run_op("mul_7_n3",      1, 0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, MLAT, 0);
    run_op("mul_ovf",       1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1, MLAT, 0);
    run_op("div_n100_7",    0, 1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 0, DLAT, 0);
    run_op("div_100_n7",    0, 1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 0, DLAT, 1);
    run_op("div_7_100",     0, 1, 32'd7,        32'd100,      32'h00000000, 0, DLAT, 0);
    run_op("div_by_zero",   0, 1, 32'd5,        32'd0,        32'h00000000, 1, 1,    0);
    run_op("div_min_n1",    0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, DLAT, 0);
    run_op("div_min_1",     0, 1, 32'h80000000, 32'd1,        32'h80000000, 0, DLAT, 0);
    run_op("both_mul_wins", 1, 1, 32'd6,        32'd0,        32'h00000000, 0, MLAT, 0);
    run_op("mul_min_1",     1, 0, 32'h80000000, 32'd1,        32'h80000000, 0, MLAT, 1);
    run_op("mul_3_min",     1, 0, 32'd3,        32'h80000000, 32'h80000000, 1, MLAT, 0);
    run_op("mul_min_n1",    1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, MLAT, 0);

    @(posedge clk); #2;
    ctrl_mult = 1'b1; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #2;
    ctrl_mult = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_result", result, 0);
    chk("abort_exception", exception, 0);
    chk("abort_stall", stall, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    rdy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_rdy) rdy_cnt++;
    end
    chk("abort_no_rdy", rdy_cnt, 0);

    run_op("mul_n1_n1",     1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, MLAT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
